// File: rtl/sega_pad_pkg.sv
// Shared constants for the Mega Drive pad responder: button bit positions,
// phase counter sizing and the default select-idle timeout.
package sega_pad_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;

  localparam int                FALL_W   = 3;
  localparam logic [FALL_W-1:0] FALL_SIX = 3'd3;
  localparam logic [FALL_W-1:0] FALL_SAT = 3'd4;

  // 1.5 ms at 24 MHz
  localparam int TIMEOUT_DEFAULT = 36000;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic p6;
    logic p9;
  } pins_t;

endpackage

// File: rtl/sega6_pad_responder_sync_edge_detect.sv
// Two-flop synchronizer for the host select line plus a registered previous
// level, giving the clean level and single-cycle fall/rise strobes.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  logic meta;
  logic level_q;
  logic prev;

  // Select idles high, so every stage resets to 1 to avoid a false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b1;
      level_q <= 1'b1;
      prev    <= 1'b1;
    end else begin
      meta    <= din;
      level_q <= meta;
      prev    <= level_q;
    end
  end

  assign level = level_q;
  assign fall  = prev & ~level_q;
  assign rise  = ~prev & level_q;

endmodule

// File: rtl/sega6_pad_responder.sv
// Controller side of the Mega Drive joystick protocol. Six-button phase
// sequencing is enabled by defining SEGA6_SIX_BUTTON_EN; otherwise a 3-button pad.
module sega6_pad_responder
  import sega_pad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int TO_W           = 16
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        select_i,
  input  logic [11:0] buttons_n_i,
  output logic        up_n_o,
  output logic        down_n_o,
  output logic        left_n_o,
  output logic        right_n_o,
  output logic        p6_n_o,
  output logic        p9_n_o
);

  logic  sel;
  logic  fall;
  logic  rise;
  pins_t pins_d;
  pins_t pins_q;

  sync_edge_detect u_sync (
    .clk   (clk_i),
    .rst_n (res_n_i),
    .din   (select_i),
    .level (sel),
    .fall  (fall),
    .rise  (rise)
  );

`ifdef SEGA6_SIX_BUTTON_EN
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [FALL_W-1:0] fall_cnt;
  logic [FALL_W-1:0] fall_cnt_d;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_cnt_d;

  function automatic pins_t map_pins(input logic sel_l, input logic [FALL_W-1:0] fc,
                                     input logic [11:0] b);
    pins_t p;
    if (sel_l && fc == FALL_SIX)
      p = {b[BTN_Z], b[BTN_Y], b[BTN_X], b[BTN_MODE], b[BTN_B], b[BTN_C]};
    else if (sel_l)
      p = {b[BTN_UP], b[BTN_DOWN], b[BTN_LEFT], b[BTN_RIGHT], b[BTN_B], b[BTN_C]};
    else if (fc == FALL_SIX)
      p = {4'b0000, b[BTN_A], b[BTN_START]};
    else if (fc == FALL_SAT)
      p = {4'b1111, b[BTN_A], b[BTN_START]};
    else
      p = {b[BTN_UP], b[BTN_DOWN], 2'b00, b[BTN_A], b[BTN_START]};
    return p;
  endfunction

  // An edge always wins over an expiry landing in the same cycle
  always_comb begin
    fall_cnt_d = fall_cnt;
    to_cnt_d   = to_cnt;
    if (fall || rise) begin
      to_cnt_d = '0;
      if (fall && fall_cnt != FALL_SAT)
        fall_cnt_d = fall_cnt + 1'b1;
    end else if (to_cnt != TO_MAX) begin
      to_cnt_d = to_cnt + 1'b1;
      if (to_cnt_d == TO_MAX)
        fall_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      fall_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      fall_cnt <= fall_cnt_d;
      to_cnt   <= to_cnt_d;
    end
  end

  // Map with the next phase so the pins settle in the same cycle the edge is seen
  assign pins_d = map_pins(sel, fall_cnt_d, buttons_n_i);
`else
  logic unused_cfg;

  function automatic pins_t map_pins(input logic sel_l, input logic [7:0] b);
    pins_t p;
    if (sel_l)
      p = {b[BTN_UP], b[BTN_DOWN], b[BTN_LEFT], b[BTN_RIGHT], b[BTN_B], b[BTN_C]};
    else
      p = {b[BTN_UP], b[BTN_DOWN], 2'b00, b[BTN_A], b[BTN_START]};
    return p;
  endfunction

  assign unused_cfg = ^{rise, fall, buttons_n_i[11:8], TO_W'(TIMEOUT_CYCLES)};
  assign pins_d     = map_pins(sel, buttons_n_i[7:0]);
`endif

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) pins_q <= '1;
    else          pins_q <= pins_d;
  end

  assign up_n_o    = pins_q.up;
  assign down_n_o  = pins_q.down;
  assign left_n_o  = pins_q.left;
  assign right_n_o = pins_q.right;
  assign p6_n_o    = pins_q.p6;
  assign p9_n_o    = pins_q.p9;

endmodule

// File: tb/tb_sega6_pad_responder.sv
// Bench for sega6_pad_responder: directed protocol sequences plus random select
// phases, checked against a phase-count model (follows SEGA6_SIX_BUTTON_EN).
module tb_sega6_pad_responder;

  localparam int T = 36000;

  logic        clk = 1'b0;
  logic        res_n_i = 1'b0;
  logic        select_i = 1'b1;
  logic [11:0] buttons_n_i = 12'hFFF;
  logic        up_n_o, down_n_o, left_n_o, right_n_o, p6_n_o, p9_n_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: host select level, falling-edge phase count,
  // current buttons and cycles elapsed since the last select transition.
  bit          m_lvl = 1'b1;
  int          m_cnt = 0;
  logic [11:0] m_btn = 12'hFFF;
  int          since_edge = 0;

  always #5 clk = ~clk;

  sega6_pad_responder #(.TIMEOUT_CYCLES(T), .TO_W(16)) dut (
    .clk_i       (clk),
    .res_n_i     (res_n_i),
    .select_i    (select_i),
    .buttons_n_i (buttons_n_i),
    .up_n_o      (up_n_o),
    .down_n_o    (down_n_o),
    .left_n_o    (left_n_o),
    .right_n_o   (right_n_o),
    .p6_n_o      (p6_n_o),
    .p9_n_o      (p9_n_o)
  );

  // Expected pins {U,D,L,R,p6,p9} for a select level and phase count.
  function automatic logic [5:0] model_pins(input bit lvl, input int cnt, input logic [11:0] b);
    int ph;
    ph = cnt;
`ifndef SEGA6_SIX_BUTTON_EN
    ph = 0;
`endif
    if (lvl && ph == 3)  return {b[8], b[9], b[10], b[11], b[4], b[5]};
    if (lvl)             return {b[0], b[1], b[2], b[3], b[4], b[5]};
    if (ph == 3)         return {4'b0000, b[6], b[7]};
    if (ph >= 4)         return {4'b1111, b[6], b[7]};
    return {b[0], b[1], 2'b00, b[6], b[7]};
  endfunction

  task automatic check(input string tag);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {up_n_o, down_n_o, left_n_o, right_n_o, p6_n_o, p9_n_o};
    exp = model_pins(m_lvl, m_cnt, m_btn);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b (lvl=%0d cnt=%0d btn=%h)",
             tag, obs, exp, m_lvl, m_cnt, m_btn);
    end
  endtask

  task automatic check_all_high(input string tag);
    logic [5:0] obs;
    obs = {up_n_o, down_n_o, left_n_o, right_n_o, p6_n_o, p9_n_o};
    n_cmp++;
    assert (obs === 6'b111111)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b expected 111111", tag, obs);
    end
  endtask

  // Called at a negedge; returns at the negedge 'hold' cycles later.
  task automatic drive(input bit lvl, input logic [11:0] b, input int hold, input string tag);
    logic [11:0] b2;
    if (lvl != m_lvl) begin
      if (since_edge - 1 >= T) m_cnt = 0;
      if (!lvl) m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
      since_edge = 0;
    end
    since_edge += hold;
    m_lvl = lvl;
    m_btn = b;
    select_i = lvl;
    buttons_n_i = b;
    repeat (3) @(negedge clk);
    check(tag);
    if (hold >= 5) begin
      b2 = 12'($urandom);
      m_btn = b2;
      buttons_n_i = b2;
      @(negedge clk);
      check({tag, "_btn"});
      repeat (hold - 4) @(negedge clk);
    end else begin
      repeat (hold - 3) @(negedge clk);
    end
  endtask

  // Asynchronous reset mid-cycle; returns at a negedge with reset released.
  task automatic do_reset(input string tag);
    #2 res_n_i = 1'b0;
    #1 check_all_high(tag);
    select_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    res_n_i = 1'b1;
    m_lvl = 1'b1;
    m_cnt = 0;
    since_edge = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_high("reset_state");
    res_n_i = 1'b1;

    drive(1'b1, 12'hFFE, 6, "idle_up");
    drive(1'b0, 12'hF3F, 6, "first_low_start_a");

    do_reset("reset_seq2");
    drive(1'b0, 12'hFFF, 6, "fall1");
    drive(1'b1, 12'hFFF, 6, "rise1");
    drive(1'b0, 12'hFFF, 6, "fall2");
    drive(1'b1, 12'hFFF, 6, "rise2");
    drive(1'b0, 12'hFFF, 6, "fall3_six_sig");
    drive(1'b1, 12'h6FF, 6, "rise3_mode_z");
    drive(1'b0, 12'hFFF, 6, "fall4_all_high");
    drive(1'b1, 12'hFFF, 6, "rise4_std");

    // Exactly T idle cycles after the rise: the phase returns to 0
    do_reset("reset_seq3");
    drive(1'b0, 12'hFFF, 6, "to_fall1");
    drive(1'b1, 12'hFFF, 6, "to_rise1");
    drive(1'b0, 12'hFFF, 6, "to_fall2");
    drive(1'b1, 12'hFFF, 6, "to_rise2");
    drive(1'b0, 12'hFFF, 6, "to_fall3");
    drive(1'b1, 12'hFFF, T + 1, "to_long_high");
    drive(1'b0, 12'hF3E, 6, "to_expired_fall");
    drive(1'b1, 12'hFFF, 6, "to_rise_b");
    drive(1'b0, 12'hFFF, 6, "to_fall_b2");
    drive(1'b1, 12'hFFF, 6, "to_rise_b2");
    drive(1'b0, 12'hFFF, 6, "to_fall_b3");
    // One cycle short of the timeout: counting continues to saturation
    drive(1'b1, 12'hFFF, T, "to_short_high");
    drive(1'b0, 12'hFFF, 6, "to_not_expired_fall");
    drive(1'b1, 12'hFFF, 6, "to_rise_after_sat");

    do_reset("reset_rand");
    for (int i = 0; i < 120; i++) begin
      drive(~m_lvl, 12'($urandom), int'($urandom_range(4, 12)), "rand_phase");
      if (i == 60) do_reset("reset_mid_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
